// File: rtl/data_bus_responder.sv
// data_bus_responder: synchronous-read data RAM plus an I/O page with TX FIFO, timer and sticky IRQ
module data_bus_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [RAM_WORDS];
  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic overflow, pending;
  logic [31:0] timer, cmp, io_rdata, rdata_next;
  logic is_ram, is_io, io_we, full, empty, pop, tx_wr, push;
  logic [2:0] idx;
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];
  // Bit 31 is covered too, so the upper half never decodes as RAM
  assign is_ram = ~|mem_addr[31:AW+2];
  assign is_io = mem_addr[31:8] == IO_BASE[31:8];
  assign io_we = mem_write & is_io;
  assign idx = mem_addr[4:2];
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_valid = ~empty;
  assign tx_data = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop = tx_valid & tx_ready;
  assign tx_wr = io_we & (idx == 3'd0);
  assign push = tx_wr & (~full | pop);
  assign timer_irq = pending;
  always_comb begin
    io_rdata = '0;
    case (idx)
      3'd1: io_rdata = {16'h0, 8'(count), 5'h0, overflow, full, empty};
      3'd2: io_rdata = timer;
      3'd3: io_rdata = cmp;
      3'd4: io_rdata = {31'h0, pending};
      default: io_rdata = '0;
    endcase
    rdata_next = is_ram ? ram[mem_addr[AW+1:2]] : is_io ? io_rdata : '0;
  end
  // Decode gates the write so an X address cannot land anywhere in RAM
  always_ff @(posedge clk)
    if (mem_write & is_ram) ram[mem_addr[AW+1:2]] <= mem_wdata;
  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_rdata <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      timer <= '0;
      cmp <= 32'hFFFF_FFFF;
      pending <= 1'b0;
    end else begin
      mem_rdata <= rdata_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (tx_wr & full & ~pop) overflow <= 1'b1;
      else if (io_we & (idx == 3'd1)) overflow <= 1'b0;
      timer <= (io_we & (idx == 3'd2)) ? mem_wdata : timer + 32'd1;
      if (io_we & (idx == 3'd3)) cmp <= mem_wdata;
      // A match outranks a same-cycle clear
      if (timer == cmp) pending <= 1'b1;
      else if (io_we & (idx == 3'd4) & mem_wdata[0]) pending <= 1'b0;
    end
endmodule
